// File: rtl/cas_key_loader_if.sv
// Handshake and key bus between the CAS-Lock key loader and its environment.
interface cas_key_loader_if #(
  parameter int KEY_W = 64
);
  logic             start;
  logic             busy;
  logic             done;
  logic             err;
  logic             mem_req;
  logic [3:0]       mem_addr;
  logic             mem_ack;
  logic [7:0]       mem_data;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;

  modport master (
    input  start, mem_ack, mem_data,
    output busy, done, err, mem_req, mem_addr, key_out, key_valid
  );

  modport slave (
    output start, mem_ack, mem_data,
    input  busy, done, err, mem_req, mem_addr, key_out, key_valid
  );
endinterface

// File: rtl/cas_key_loader.sv
// Fetches KEY_W/8 key bytes plus an XOR checksum over req/ack, then drives the locked core's key bus.
// start-to-key_valid is NBYTES+3 edges with ack tied high; mem_req simply holds while ack is low (TIMEOUT bounded).
module cas_key_loader #(
  parameter int KEY_W   = 64,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  cas_key_loader_if.master bus
);
  localparam int         NBYTES = KEY_W / 8;
  localparam logic [3:0] LAST   = 4'(NBYTES);
  localparam logic [7:0] TLIM   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, DONE, ERR} state_t;

  state_t           state, state_nx;
  logic [3:0]       idx;
  logic [7:0]       tcnt;
  logic [7:0]       xor_acc;
  logic [7:0]       chk;
  logic [KEY_W-1:0] shadow;
  logic [KEY_W-1:0] key_q;
  logic             key_valid_q;
  logic             err_q;
  logic             done_q;
  logic             busy_w;
  logic             accept;

  assign busy_w = (state == FETCH) || (state == CHECK);
  assign accept = bus.start && !busy_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (bus.start) state_nx = FETCH;
      FETCH: begin
        if (bus.mem_ack) begin
          if (idx == LAST) state_nx = CHECK;
        end else if (tcnt == TLIM) begin
          state_nx = ERR;
        end
      end
      CHECK:   state_nx = (chk == xor_acc) ? DONE : ERR;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = busy_w;
    bus.mem_req   = (state == FETCH);
    bus.mem_addr  = (state == FETCH) ? idx : 4'd0;
    bus.done      = done_q;
    bus.err       = err_q;
    bus.key_out   = key_q;
    bus.key_valid = key_valid_q;
  end

  // Key bus only changes when a load finishes, so the old key stays live during a reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      tcnt        <= '0;
      xor_acc     <= '0;
      chk         <= '0;
      shadow      <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= busy_w && (state_nx == DONE || state_nx == ERR);
      if (accept) begin
        idx     <= '0;
        tcnt    <= '0;
        xor_acc <= '0;
        err_q   <= 1'b0;
      end else if (state == FETCH) begin
        if (bus.mem_ack) begin
          tcnt <= '0;
          if (idx == LAST) begin
            chk <= bus.mem_data;
          end else begin
            for (int i = 0; i < NBYTES; i++) begin
              if (idx == 4'(i)) shadow[8*i +: 8] <= bus.mem_data;
            end
            xor_acc <= xor_acc ^ bus.mem_data;
            idx     <= idx + 4'd1;
          end
        end else begin
          tcnt <= tcnt + 8'd1;
        end
      end
      if (state == CHECK && state_nx == DONE) begin
        key_q       <= shadow;
        key_valid_q <= 1'b1;
      end else if (busy_w && state_nx == ERR) begin
        key_q       <= '0;
        key_valid_q <= 1'b0;
        err_q       <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cas_key_loader.sv
// Scoreboard bench: expected keys and address sequences are queued at start and retired on done.
module tb_cas_key_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   ack_mode = 0;
  int   cyc = 0;
  logic [7:0] mem [16];

  typedef struct {
    logic [63:0] key;
    logic        kv;
    logic        err;
  } res_t;

  res_t       exp_q[$];
  logic [3:0] exp_addr[$];
  logic [3:0] obs_addr[$];

  cas_key_loader_if #(.KEY_W(64)) bus ();
  cas_key_loader_if #(.KEY_W(64)) bus2 ();

  cas_key_loader #(.KEY_W(64), .TIMEOUT(255)) dut (.clk(clk), .rst(rst), .bus(bus));
  cas_key_loader #(.KEY_W(64), .TIMEOUT(4))   dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_data  = mem[bus.mem_addr];
  assign bus.mem_ack   = (ack_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  assign bus2.mem_data = mem[bus2.mem_addr];
  assign bus2.mem_ack  = (bus2.mem_addr <= 4'd2);

  always @(negedge clk) begin
    if (bus.mem_req && bus.mem_ack) obs_addr.push_back(bus.mem_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_mem(input logic [63:0] k, input logic [7:0] c);
    for (int i = 0; i < 8; i++) mem[i] = k[8*i +: 8];
    mem[8] = c;
  endtask

  task automatic launch(input logic [63:0] k, input logic kv, input logic e);
    res_t r;
    r.key = k; r.kv = kv; r.err = e;
    exp_q.push_back(r);
    for (int a = 0; a <= 8; a++) exp_addr.push_back(4'(a));
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rst_done got %b want 0", bus.done); else passes++;
    checks++; if (bus.err !== 1'b0) $display("FAIL rst_err got %b want 0", bus.err); else passes++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req got %b want 0", bus.mem_req); else passes++;
    checks++; if (bus.mem_addr !== 4'd0) $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); else passes++;
    checks++; if (bus.key_valid !== 1'b0) $display("FAIL rst_key_valid got %b want 0", bus.key_valid); else passes++;
    checks++; if (bus.key_out !== 64'd0) $display("FAIL rst_key_out got %h want 0", bus.key_out); else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_good_load();
    int n;
    res_t r;
    logic [3:0] e, o;
    ack_mode = 0;
    set_mem(64'h0123_4567_89AB_CDEF, 8'h00);
    launch(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    n = 1;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 4'd0)
      $display("FAIL start_latency got req=%b addr=%h want req=1 addr=0", bus.mem_req, bus.mem_addr); else passes++;
    while (!bus.key_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    checks++; if (n !== 11) $display("FAIL load_latency got %0d edges want 11", n); else passes++;
    checks++; if (bus.done !== 1'b1) $display("FAIL good_done got %b want 1", bus.done); else passes++;
    r = exp_q.pop_front();
    checks++; if (bus.key_out !== r.key) $display("FAIL good_key got %h want %h", bus.key_out, r.key); else passes++;
    checks++; if (bus.err !== r.err) $display("FAIL good_err got %b want %b", bus.err, r.err); else passes++;
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) $display("FAIL good_done_width got %b want 0", bus.done); else passes++;
    while (exp_addr.size() > 0) begin
      e = exp_addr.pop_front();
      o = (obs_addr.size() > 0) ? obs_addr.pop_front() : 4'hF;
      checks++; if (o !== e) $display("FAIL good_addr got %h want %h", o, e); else passes++;
    end
    checks++; if (obs_addr.size() !== 0) $display("FAIL good_extra_xfers got %0d want 0", obs_addr.size()); else passes++;
  endtask

  task automatic test_reload_slow();
    int bad;
    bit seen;
    res_t r;
    logic [3:0] e, o;
    logic [63:0] old_key;
    old_key = 64'h0123_4567_89AB_CDEF;
    ack_mode = 1;
    set_mem(64'h0000_0000_0000_00A5, 8'hA5);
    launch(64'h0000_0000_0000_00A5, 1'b1, 1'b0);
    bad = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.key_out !== old_key || bus.key_valid !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    checks++; if (seen !== 1'b1) $display("FAIL reload_done got %b want 1", seen); else passes++;
    checks++; if (bad !== 0) $display("FAIL reload_old_key_held got %0d bad cycles want 0", bad); else passes++;
    r = exp_q.pop_front();
    checks++; if (bus.key_out !== r.key) $display("FAIL reload_key got %h want %h", bus.key_out, r.key); else passes++;
    checks++; if (bus.key_valid !== r.kv) $display("FAIL reload_kv got %b want %b", bus.key_valid, r.kv); else passes++;
    while (exp_addr.size() > 0) begin
      e = exp_addr.pop_front();
      o = (obs_addr.size() > 0) ? obs_addr.pop_front() : 4'hF;
      checks++; if (o !== e) $display("FAIL reload_addr got %h want %h", o, e); else passes++;
    end
  endtask

  task automatic test_bad_checksum();
    bit seen;
    res_t r;
    ack_mode = 0;
    set_mem(64'h0123_4567_89AB_CDEF, 8'h01);
    launch(64'd0, 1'b0, 1'b1);
    wait_done(40, seen);
    checks++; if (seen !== 1'b1) $display("FAIL bad_done got %b want 1", seen); else passes++;
    r = exp_q.pop_front();
    checks++; if (bus.err !== r.err) $display("FAIL bad_err got %b want %b", bus.err, r.err); else passes++;
    checks++; if (bus.key_valid !== r.kv) $display("FAIL bad_kv got %b want %b", bus.key_valid, r.kv); else passes++;
    checks++; if (bus.key_out !== r.key) $display("FAIL bad_key got %h want %h", bus.key_out, r.key); else passes++;
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0 || bus.err !== 1'b1)
      $display("FAIL bad_after got done=%b err=%b want done=0 err=1", bus.done, bus.err); else passes++;
    exp_addr.delete();
    obs_addr.delete();
  endtask

  task automatic test_timeout();
    int n;
    set_mem(64'h0123_4567_89AB_CDEF, 8'h00);
    @(negedge clk);
    bus2.start = 1'b1;
    @(posedge clk);
    #1 bus2.start = 1'b0;
    n = 1;
    while (n < 7) begin
      @(posedge clk);
      #1 n++;
    end
    checks++; if (bus2.mem_req !== 1'b1 || bus2.mem_addr !== 4'd3)
      $display("FAIL tmo_pre got req=%b addr=%h want req=1 addr=3", bus2.mem_req, bus2.mem_addr); else passes++;
    checks++; if (bus2.err !== 1'b0) $display("FAIL tmo_pre_err got %b want 0", bus2.err); else passes++;
    @(posedge clk);
    #1;
    checks++; if (bus2.mem_req !== 1'b0) $display("FAIL tmo_req got %b want 0", bus2.mem_req); else passes++;
    checks++; if (bus2.err !== 1'b1) $display("FAIL tmo_err got %b want 1", bus2.err); else passes++;
    checks++; if (bus2.done !== 1'b1) $display("FAIL tmo_done got %b want 1", bus2.done); else passes++;
    checks++; if (bus2.key_out !== 64'd0 || bus2.key_valid !== 1'b0)
      $display("FAIL tmo_key got %h kv=%b want 0 kv=0", bus2.key_out, bus2.key_valid); else passes++;
  endtask

  task automatic test_back_to_back();
    res_t r;
    logic [3:0] e, o;
    ack_mode = 0;
    set_mem(64'h0123_4567_89AB_CDEF, 8'h00);
    r.key = 64'h0123_4567_89AB_CDEF; r.kv = 1'b1; r.err = 1'b0;
    exp_q.push_back(r);
    for (int a = 0; a <= 8; a++) exp_addr.push_back(4'(a));
    @(negedge clk);
    bus.start = 1'b1;
    repeat (11) @(posedge clk);
    #1 bus.start = 1'b0;
    checks++; if (bus.done !== 1'b1) $display("FAIL b2b_done got %b want 1", bus.done); else passes++;
    r = exp_q.pop_front();
    checks++; if (bus.key_out !== r.key || bus.key_valid !== r.kv)
      $display("FAIL b2b_key got %h kv=%b want %h kv=%b", bus.key_out, bus.key_valid, r.key, r.kv); else passes++;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_start_at_done got busy=%b want 0", bus.busy); else passes++;
    while (exp_addr.size() > 0) begin
      e = exp_addr.pop_front();
      o = (obs_addr.size() > 0) ? obs_addr.pop_front() : 4'hF;
      checks++; if (o !== e) $display("FAIL b2b_addr got %h want %h", o, e); else passes++;
    end
    checks++; if (obs_addr.size() !== 0) $display("FAIL b2b_extra_xfers got %0d want 0", obs_addr.size()); else passes++;
  endtask

  task automatic test_async_reset();
    bit seen;
    res_t r;
    ack_mode = 1;
    set_mem(64'h0000_0000_0000_00A5, 8'hA5);
    launch(64'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL arst_req got req=%b busy=%b want 0 0", bus.mem_req, bus.busy); else passes++;
    checks++; if (bus.key_out !== 64'd0 || bus.key_valid !== 1'b0)
      $display("FAIL arst_key got %h kv=%b want 0 kv=0", bus.key_out, bus.key_valid); else passes++;
    #1 rst = 1'b0;
    void'(exp_q.pop_front());
    exp_addr.delete();
    obs_addr.delete();
    ack_mode = 0;
    set_mem(64'hDEAD_BEEF_0BAD_F00D, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h0B ^ 8'hAD ^ 8'hF0 ^ 8'h0D);
    launch(64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b0);
    wait_done(40, seen);
    checks++; if (seen !== 1'b1) $display("FAIL arst_reload_done got %b want 1", seen); else passes++;
    r = exp_q.pop_front();
    checks++; if (bus.key_out !== r.key || bus.key_valid !== r.kv || bus.err !== r.err)
      $display("FAIL arst_reload_key got %h kv=%b err=%b want %h kv=%b err=%b",
               bus.key_out, bus.key_valid, bus.err, r.key, r.kv, r.err); else passes++;
    exp_addr.delete();
    obs_addr.delete();
  endtask

  initial begin
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_good_load();
    test_reload_slow();
    test_bad_checksum();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cas_key_loader.md
# cas_key_loader

Sequential key-provisioning controller for the CAS-Lock protected c1355 netlist. It fetches the 64-bit locking key and a checksum byte from byte-wide on-chip key storage over a request/acknowledge interface. It checks integrity, then drives the `keyinput_0..63` bus of the locked core. The key bus is zero and `key_valid` is low until a load completes successfully, and both return to that state after any failed load.

## Interface
Parameters:
- `KEY_W`, 64: key width; must be a multiple of 8.
- `NBYTES`, KEY_W/8: number of key bytes; derived, not overridable.
- `TIMEOUT`, 255: maximum consecutive FETCH cycles without `mem_ack` before the load aborts (1..255).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle load request; sampled only in IDLE, DONE or ERR.
- `busy` out 1: high in FETCH and CHECK.
- `done` out 1: one-cycle pulse when a load ends, whether it passed or failed.
- `err` out 1: high from a failed load until the next accepted `start` or reset.
- `mem_req` out 1: read request to key storage.
- `mem_addr` out 4: byte address. Addresses 0..NBYTES-1 hold key bytes; address NBYTES holds the checksum.
- `mem_ack` in 1: the transfer completes in any cycle where `mem_req` and `mem_ack` are both high.
- `mem_data` in 8: read data, valid in the ack cycle.
- `key_out` out KEY_W: drives `keyinput_[KEY_W-1:0]`. Byte i maps to bits [8i+7:8i].
- `key_valid` out 1: high while `key_out` holds a verified key.

## Operation
- States:
  - IDLE: reset state; waits for `start`.
  - FETCH: `mem_req`=1 and `mem_addr`=byte index.
  - CHECK: compares the captured checksum.
  - DONE: load passed; holds the key.
  - ERR: load failed; key is zeroed.
- Accepted `start` (in IDLE, DONE or ERR):
  - clears byte index, timeout counter, running XOR and `err`;
  - goes to FETCH;
  - leaves `key_out` and `key_valid` unchanged, so the previous verified key stays live during the reload.
- FETCH transfers:
  - Each acked cycle with index < NBYTES writes `mem_data` into shadow byte[index], XORs it into the running checksum, increments the index and clears the timeout counter.
  - `mem_req` stays high for back-to-back transfers; `mem_addr` changes on the clock edge after each ack.
- FETCH exit:
  - The ack with index = NBYTES captures the checksum byte; `mem_req` drops and the state goes to CHECK.
  - A non-acked FETCH cycle increments the timeout counter. When the counter reaches TIMEOUT, `mem_req` drops and the state goes to ERR with a `done` pulse.
- CHECK outcome:
  - Checksum == XOR of all key bytes: copy the shadow register into `key_out` in one edge, set `key_valid`=1, pulse `done`, go to DONE.
  - Mismatch: set `key_out`=0, `key_valid`=0, `err`=1, pulse `done`, go to ERR.
- Timeout abort: same outputs as a mismatch.
- `start` while `busy` is ignored (no queueing).
- `mem_ack` while `mem_req` is low is ignored.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE;
  - `busy`, `done`, `err`, `mem_req`, `key_valid` = 0;
  - `mem_addr` = 0, `key_out` = 0;
  - shadow register and counters = 0.
- Reset in mid-load aborts at once; `mem_req` falls without waiting for a clock.
- Start latency: `start` sampled at edge E gives `mem_req`=1 and `mem_addr`=0 after E.
- Minimum load time: with `mem_ack` tied high, acks occur on cycles E+1..E+NBYTES+1 (9 cycles for KEY_W=64).
  - CHECK occupies the cycle after the last ack.
  - `key_out`, `key_valid` and `done` update on the following edge.
  - Total `start` to `key_valid`: NBYTES+3 edges (11 for KEY_W=64).
- `done` is high for exactly one cycle.
- `err` and `key_valid` are never high together.
- Simultaneous `start` and the `done` edge: `start` is not sampled, because the state is still CHECK.

## Test plan
- Key 64'h0123_4567_89AB_CDEF stored as bytes EF,CD,AB,89,67,45,23,01, checksum 0x00, `mem_ack` tied high, `start` pulse:
  - `key_valid`=1 and `key_out`=64'h0123456789ABCDEF after exactly 11 edges;
  - `done` high for 1 cycle; `err`=0.
- Same key with checksum 0x01: `done` pulse, `err`=1, `key_valid`=0, `key_out`=0.
- Reload after a good load with key 64'h0000_0000_0000_00A5 and checksum 0xA5, `mem_ack` asserted every 3rd cycle:
  - old key stays on `key_out` with `key_valid`=1 throughout;
  - switches atomically to 64'hA5 on `done`.
- TIMEOUT=4, `mem_ack` never asserted after byte 2: ERR on the 4th idle FETCH cycle, `mem_req`=0, `err`=1, `key_out`=0.
- Async `rst` pulsed between clock edges during FETCH after a good key is loaded: all outputs zero immediately; a following `start` loads normally.
- `start` pulsed again while `busy`: ignored; `mem_addr` sequence 0..8 continues unchanged.
